sync_tx_arbiter: RTL and testbench

//  Source-domain controller that shares one multi-flop bus synchronizer channel among NUM_REQ requesters.

---
 rtl/sync_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sync_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_sync_tx_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_ctrl_pkg.sv
// Shared encodings for the source-side sync channel controller.
// FSM states and timer sizing helper.
package sync_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  // Timer must hold TIMEOUT; keep at least one bit when timeout is off.
  function automatic int tmr_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping.
// Purely combinational; grant is one-hot, idx is its position.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx
);

  // Scan from ptr upward and keep the first hit.
  always_comb begin
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      j = int'(ptr) + o;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sync_tx_arbiter.sv
// Shares one 4-phase req/ack sync channel among NUM_REQ sources.
// Round-robin capture onto tx_bus, ack synchronized internally.
module sync_tx_arbiter
  import sync_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  input  logic                         clr_err,
  output logic [NUM_REQ-1:0]           req_grant,
  output logic [BUS_WIDTH-1:0]         tx_bus,
  output logic                         tx_req,
  input  logic                         tx_ack_async,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = tmr_width(TIMEOUT);

  state_e                 state_q, state_d;
  logic [NUM_STAGES-1:0]  sync_q;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [BUS_WIDTH-1:0]   bus_q, bus_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   txreq_q, txreq_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   ack_s;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [PW-1:0]          arb_idx;
  logic [TW-1:0]          tmr_inc;
  logic                   tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  assign ack_s = sync_q[NUM_STAGES-1];

  // Ack synchronizer chain; only its last flop is observed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[NUM_STAGES-2:0], tx_ack_async};
  end

  // Saturating phase timer and its expiry test.
  assign tmr_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);
  assign tmo = (TIMEOUT != 0) && (int'(timer_q) + 1 >= TIMEOUT);

  // Next-state and registered-output logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    bus_d   = bus_q;
    grant_d = '0;
    txreq_d = txreq_q;
    done_d  = 1'b0;
    err_d   = clr_err ? 1'b0 : err_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          bus_d   = req_data[arb_idx*BUS_WIDTH +: BUS_WIDTH];
          grant_d = arb_gnt;
          ptr_d   = (arb_idx == PW'(NUM_REQ-1)) ? '0 : arb_idx + PW'(1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        txreq_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        timer_d = tmr_inc;
        if (ack_s) begin
          txreq_d = 1'b0;
          timer_d = '0;
          state_d = WAIT_REL;
        end else if (tmo) begin
          txreq_d = 1'b0;
          err_d   = 1'b1;
          timer_d = '0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        timer_d = tmr_inc;
        if (!ack_s) begin
          done_d  = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else if (tmo) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      timer_q <= '0;
      bus_q   <= '0;
      grant_q <= '0;
      txreq_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      bus_q   <= bus_d;
      grant_q <= grant_d;
      txreq_q <= txreq_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_grant   = grant_q;
  assign tx_bus      = bus_q;
  assign tx_req      = txreq_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed bench for sync_tx_arbiter with a delayed-ack destination.
// Ack model: echoes tx_req three falling edges later; can be muted or stuck.
module tb_sync_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        clr_err = 1'b0;
  logic [3:0]  req_grant;
  logic [7:0]  tx_bus;
  logic        tx_req;
  logic        tx_ack_async = 1'b0;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int   tests = 0;
  int   fails = 0;
  int   ack_mode = 0;
  logic [2:0] dly = '0;
  logic stuck = 1'b0;

  always #5 CLK = ~CLK;

  sync_tx_arbiter #(
    .NUM_REQ    (4),
    .BUS_WIDTH  (8),
    .NUM_STAGES (2),
    .TIMEOUT    (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req          (req),
    .req_data     (req_data),
    .clr_err      (clr_err),
    .req_grant    (req_grant),
    .tx_bus       (tx_bus),
    .tx_req       (tx_req),
    .tx_ack_async (tx_ack_async),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  // Destination model: mode 0 echo, 1 silent, 2 echo then stick high.
  always @(negedge CLK) begin
    dly = {dly[1:0], tx_req};
    if (ack_mode != 2) stuck = 1'b0;
    else if (dly[2]) stuck = 1'b1;
    tx_ack_async = (ack_mode == 1) ? 1'b0 : (dly[2] | stuck);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One normal transfer: grant, capture, 5-cycle ack and release phases.
  task automatic xfer(input string tag, input logic [3:0] eg,
                      input logic [7:0] ed, input bit drop, input bit chg);
    int n;
    n = 0;
    do begin tick(); n++; end while (req_grant == 4'd0 && n < 40);
    chk({tag, " lat"}, n, 1);
    chk({tag, " gnt"}, {28'd0, req_grant}, {28'd0, eg});
    chk({tag, " cap"}, {23'd0, tx_req, tx_bus}, {24'd0, ed});
    if (drop) req = req & ~req_grant;
    if (chg) req_data[23:16] = 8'h3C;
    tick();
    chk({tag, " rise"}, {19'd0, req_grant, tx_req, tx_bus},
        {24'd1, ed});
    n = 0;
    while (tx_req === 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, " ackw"}, n, 5);
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, " relw"}, n, 5);
    chk({tag, " end"}, {23'd0, busy, tx_bus}, {24'd0, ed});
  endtask

  initial begin
    int   n;
    logic seen;

    repeat (3) tick();
    chk("rst", {19'd0, req_grant, tx_bus, tx_req, busy, done, timeout_err},
        32'd0);
    RST = 1'b0;
    tick();

    // Reset in the middle of WAIT_ACK.
    req_data[23:16] = 8'h11;
    req = 4'b0100;
    tick();
    chk("t1 pre gnt", {28'd0, req_grant}, 32'h4);
    req = '0;
    tick();
    tick();
    chk("t1 wack", {31'd0, tx_req}, 32'd1);
    RST = 1'b1;
    #1;
    chk("t1 in rst", {18'd0, req_grant, tx_bus, tx_req, busy}, 32'd0);
    repeat (4) tick();
    RST = 1'b0;
    req_data[7:0]   = 8'h0F;
    req_data[31:24] = 8'hF0;
    req = 4'b1001;
    xfer("t1 post", 4'b0001, 8'h0F, 1'b1, 1'b0);
    req = '0;
    tick();
    tick();
    chk("t1 drop", {27'd0, req_grant, busy}, 32'd0);

    // Single requester 2, data changed right after grant.
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    xfer("t2", 4'b0100, 8'hA5, 1'b1, 1'b1);

    // All requesters held: rotate 0,1,2,3,0 back to back.
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1000;
    xfer("t3 pre", 4'b1000, 8'h44, 1'b1, 1'b0);
    req = 4'b1111;
    xfer("t3 a", 4'b0001, 8'h11, 1'b0, 1'b0);
    xfer("t3 b", 4'b0010, 8'h22, 1'b0, 1'b0);
    xfer("t3 c", 4'b0100, 8'h33, 1'b0, 1'b0);
    xfer("t3 d", 4'b1000, 8'h44, 1'b0, 1'b0);
    xfer("t3 e", 4'b0001, 8'h11, 1'b0, 1'b0);
    req = '0;

    // Ack never returns: WAIT_ACK timeout after 16 cycles.
    tick();
    ack_mode = 1;
    req_data[15:8] = 8'h77;
    req = 4'b0010;
    tick();
    chk("t5 gnt", {28'd0, req_grant}, 32'h2);
    req = '0;
    tick();
    chk("t5 rise", {31'd0, tx_req}, 32'd1);
    n = 0;
    while (tx_req === 1'b1 && n < 40) begin tick(); n++; end
    chk("t5 tmo cyc", n, 16);
    chk("t5 err", {31'd0, timeout_err}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin tick(); n++; end
    chk("t5 idle", n, 1);
    repeat (3) tick();
    ack_mode = 0;
    chk("t5 sticky", {31'd0, timeout_err}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t5 clr", {31'd0, timeout_err}, 32'd0);
    req_data[31:24] = 8'h99;
    req = 4'b1000;
    xfer("t5 next", 4'b1000, 8'h99, 1'b1, 1'b0);

    // Ack stuck high: WAIT_REL timeout, no done.
    tick();
    ack_mode = 2;
    req_data[7:0] = 8'hC3;
    req = 4'b0001;
    tick();
    chk("t6 gnt", {28'd0, req_grant}, 32'h1);
    req = '0;
    tick();
    n = 0;
    while (tx_req === 1'b1 && n < 40) begin tick(); n++; end
    chk("t6 ackw", n, 5);
    n = 0;
    seen = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("t6 rel cyc", n, 16);
    chk("t6 no done", {31'd0, seen}, 32'd0);
    chk("t6 err", {31'd0, timeout_err}, 32'd1);
    ack_mode = 0;
    repeat (6) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t6 clr", {30'd0, timeout_err, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
